// File: rtl/pipe_fetch_stage_if.sv
// rtl/pipe_fetch_stage_if.sv - fetch-stage bus: imem address/data, hazard controls, IF/ID outputs, counters
interface pipe_fetch_stage_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      pc_o;
  logic [31:0]      imem_instr_i;
  logic             stall_i;
  logic             redirect_i;
  logic [31:0]      redirect_pc_i;
  logic             flush_i;
  logic [31:0]      if_id_pc4_o;
  logic [31:0]      if_id_instr_o;
  logic             if_id_valid_o;
  logic [CNT_W-1:0] fetch_cnt_o;
  logic [CNT_W-1:0] stall_cnt_o;

  // Pipeline control / memory side that drives the fetch stage
  modport master (
    input  pc_o, if_id_pc4_o, if_id_instr_o, if_id_valid_o, fetch_cnt_o, stall_cnt_o,
    output imem_instr_i, stall_i, redirect_i, redirect_pc_i, flush_i
  );

  // The fetch stage itself
  modport slave (
    output pc_o, if_id_pc4_o, if_id_instr_o, if_id_valid_o, fetch_cnt_o, stall_cnt_o,
    input  imem_instr_i, stall_i, redirect_i, redirect_pc_i, flush_i
  );
endinterface

// File: rtl/pipe_fetch_stage.sv
// rtl/pipe_fetch_stage.sv - instruction fetch: PC, IF/ID register, stall/flush/redirect, perf counters
module pipe_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  pipe_fetch_stage_if.slave  bus
);

  logic [31:0]      r_pc;
  logic [31:0]      r_if_id_pc4;
  logic [31:0]      r_if_id_instr;
  logic             r_if_id_valid;
  logic [CNT_W-1:0] r_fetch_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [31:0]      w_pc4;
  logic             w_fetch_sat;
  logic             w_stall_sat;

  // PC arithmetic wraps modulo 2^32 by construction of the 32-bit add
  assign w_pc4       = r_pc + 32'd4;
  assign w_fetch_sat = &r_fetch_cnt;
  assign w_stall_sat = &r_stall_cnt;

  // Single priority chain: redirect > flush > stall > normal fetch
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc          <= RESET_PC;
      r_if_id_pc4   <= '0;
      r_if_id_instr <= '0;
      r_if_id_valid <= 1'b0;
      r_fetch_cnt   <= '0;
      r_stall_cnt   <= '0;
    end else if (bus.redirect_i) begin
      // Targets are word aligned; any stall this cycle is moot because IF/ID is squashed
      r_pc          <= {bus.redirect_pc_i[31:2], 2'b00};
      r_if_id_pc4   <= '0;
      r_if_id_instr <= '0;
      r_if_id_valid <= 1'b0;
    end else if (bus.flush_i) begin
      // Flush beats stall: bubble goes in and the PC keeps moving
      r_pc          <= w_pc4;
      r_if_id_pc4   <= '0;
      r_if_id_instr <= '0;
      r_if_id_valid <= 1'b0;
    end else if (bus.stall_i) begin
      if (!w_stall_sat) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end else begin
      r_pc          <= w_pc4;
      r_if_id_pc4   <= w_pc4;
      r_if_id_instr <= bus.imem_instr_i;
      r_if_id_valid <= 1'b1;
      if (!w_fetch_sat) begin
        r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.pc_o          = r_pc;
  assign bus.if_id_pc4_o   = r_if_id_pc4;
  assign bus.if_id_instr_o = r_if_id_instr;
  assign bus.if_id_valid_o = r_if_id_valid;
  assign bus.fetch_cnt_o   = r_fetch_cnt;
  assign bus.stall_cnt_o   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_fetch_stage.sv
// tb/tb_pipe_fetch_stage.sv - randomized bench for pipe_fetch_stage against a behavioural model
module tb_pipe_fetch_stage;

  logic        clk_i;
  logic        rst_i;
  logic        tb_stall;
  logic        tb_flush;
  logic        tb_redirect;
  logic [31:0] tb_redirect_pc;

  int n_chk;
  int n_fail;

  // Reference state
  logic [31:0] m_pc;
  logic [31:0] m_pc4;
  logic [31:0] m_instr;
  logic        m_valid;
  longint      m_fcnt;
  longint      m_scnt;

  pipe_fetch_stage_if #(.CNT_W(16)) u_if_a ();
  pipe_fetch_stage_if #(.CNT_W(2))  u_if_b ();

  pipe_fetch_stage #(.RESET_PC(32'h0), .CNT_W(16)) u_dut_a (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (u_if_a.slave)
  );

  pipe_fetch_stage #(.RESET_PC(32'h0), .CNT_W(2)) u_dut_b (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (u_if_b.slave)
  );

  // Instruction memory: word k holds k+1
  function automatic logic [31:0] imem(input logic [31:0] addr);
    return (addr >> 2) + 32'd1;
  endfunction

  assign u_if_a.imem_instr_i  = imem(u_if_a.pc_o);
  assign u_if_a.stall_i       = tb_stall;
  assign u_if_a.flush_i       = tb_flush;
  assign u_if_a.redirect_i    = tb_redirect;
  assign u_if_a.redirect_pc_i = tb_redirect_pc;
  assign u_if_b.imem_instr_i  = imem(u_if_b.pc_o);
  assign u_if_b.stall_i       = tb_stall;
  assign u_if_b.flush_i       = tb_flush;
  assign u_if_b.redirect_i    = tb_redirect;
  assign u_if_b.redirect_pc_i = tb_redirect_pc;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(input longint v, input longint maxv);
    return (v > maxv) ? 32'(maxv) : 32'(v);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
    m_fcnt = 0; m_scnt = 0;
  endtask

  task automatic check_all();
    check("pc_a",    u_if_a.pc_o,          m_pc);
    check("pc4_a",   u_if_a.if_id_pc4_o,   m_pc4);
    check("instr_a", u_if_a.if_id_instr_o, m_instr);
    check("valid_a", {31'd0, u_if_a.if_id_valid_o}, {31'd0, m_valid});
    check("fcnt_a",  {16'd0, u_if_a.fetch_cnt_o},   sat(m_fcnt, 65535));
    check("scnt_a",  {16'd0, u_if_a.stall_cnt_o},   sat(m_scnt, 65535));
    check("pc_b",    u_if_b.pc_o,          m_pc);
    check("fcnt_b",  {30'd0, u_if_b.fetch_cnt_o},   sat(m_fcnt, 3));
    check("scnt_b",  {30'd0, u_if_b.stall_cnt_o},   sat(m_scnt, 3));
  endtask

  // Apply one cycle of controls, advance the model by the stage's rules, compare after the edge
  task automatic step(input logic st, input logic fl, input logic rd, input logic [31:0] rpc);
    tb_stall = st; tb_flush = fl; tb_redirect = rd; tb_redirect_pc = rpc;
    if (rd) begin
      m_pc = rpc & 32'hFFFF_FFFC;
      m_pc4 = 0; m_instr = 0; m_valid = 0;
    end else if (fl) begin
      m_pc = m_pc + 32'd4;
      m_pc4 = 0; m_instr = 0; m_valid = 0;
    end else if (st) begin
      m_scnt++;
    end else begin
      m_instr = imem(m_pc);
      m_pc = m_pc + 32'd4;
      m_pc4 = m_pc;
      m_valid = 1;
      m_fcnt++;
    end
    @(posedge clk_i);
    #1;
    check_all();
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      logic st, fl, rd;
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 9) == 0);
      rd = ($urandom_range(0, 11) == 0);
      step(st, fl, rd, $urandom);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_i = 1'b0;
    tb_stall = 0; tb_flush = 0; tb_redirect = 0; tb_redirect_pc = 0;
    model_reset();
    #1;
    check_all();
    @(negedge clk_i);
    rst_i = 1'b1;

    // Free run: pc 0 -> 4 -> 8
    step(0, 0, 0, 0);
    check("t1_instr1", u_if_a.if_id_instr_o, 32'd1);
    step(0, 0, 0, 0);
    check("t1_pc8", u_if_a.pc_o, 32'd8);
    // Stall two cycles at pc=8
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("t2_pc_held", u_if_a.pc_o, 32'd8);
    check("t2_instr_held", u_if_a.if_id_instr_o, 32'd2);
    check("t2_scnt", {16'd0, u_if_a.stall_cnt_o}, 32'd2);
    step(0, 0, 0, 0);
    check("t2_resume", u_if_a.if_id_instr_o, 32'd3);
    check("t2_pc4", u_if_a.if_id_pc4_o, 32'd12);
    // Redirect at pc=12 to misaligned 0x42
    step(0, 0, 1, 32'h0000_0042);
    check("t3_pc", u_if_a.pc_o, 32'h40);
    check("t3_bubble", {31'd0, u_if_a.if_id_valid_o}, 32'd0);
    step(0, 0, 0, 0);
    check("t3_instr", u_if_a.if_id_instr_o, 32'd17);
    check("t3_pc4", u_if_a.if_id_pc4_o, 32'h44);
    // Stall with redirect, then stall with flush
    step(1, 0, 1, 32'h20);
    check("t4_pc", u_if_a.pc_o, 32'h20);
    check("t4_scnt", {16'd0, u_if_a.stall_cnt_o}, 32'd2);
    step(1, 1, 0, 0);
    check("t4_flush_pc", u_if_a.pc_o, 32'h24);
    check("t4_flush_scnt", {16'd0, u_if_a.stall_cnt_o}, 32'd2);
    // PC wrap
    step(0, 0, 1, 32'hFFFF_FFFE);
    step(0, 0, 0, 0);
    check("t5_pc_wrap", u_if_a.pc_o, 32'd0);
    check("t5_pc4_wrap", u_if_a.if_id_pc4_o, 32'd0);
    check("t5_sat_b", {30'd0, u_if_b.fetch_cnt_o}, 32'd3);

    random_run(400);

    // Reset dropped between edges during a stall
    step(1, 0, 0, 0);
    #2;
    rst_i = 1'b0;
    model_reset();
    #1;
    check("t6_pc_async", u_if_a.pc_o, 32'd0);
    check("t6_valid_async", {31'd0, u_if_a.if_id_valid_o}, 32'd0);
    check_all();
    @(negedge clk_i);
    tb_stall = 0;
    rst_i = 1'b1;

    random_run(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_fetch_stage.md
Name: pipe_fetch_stage

Overview:
Instruction-fetch stage of Pipe_CPU_1. It holds the program counter and drives the instruction-memory address. It latches each fetched word into the IF/ID pipeline register and handles stalls from hazard detection and redirects from branch resolution. Two saturating performance counters (fetched, stalled cycles) are exposed for bench printout.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
CNT_W, 16, width of each performance counter.

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  asynchronous, active-low reset
pc_o  output  32  current PC; drives instruction-memory address
imem_instr_i  input  32  instruction word at pc_o, combinational from instruction memory
stall_i  input  1  hazard unit: hold PC and IF/ID contents
redirect_i  input  1  branch/jump resolved taken
redirect_pc_i  input  32  target PC for redirect
flush_i  input  1  squash IF/ID contents (insert bubble)
if_id_pc4_o  output  32  registered PC+4 of the latched instruction
if_id_instr_o  output  32  registered instruction
if_id_valid_o  output  1  latched instruction is real (not a bubble)
fetch_cnt_o  output  CNT_W  count of valid instructions latched into IF/ID
stall_cnt_o  output  CNT_W  count of cycles held by stall_i

Behaviour:
- Reset (rst_i=0, asynchronous, immediate on assertion):
  - pc_o=RESET_PC.
  - if_id_pc4_o=0, if_id_instr_o=0 (NOP), if_id_valid_o=0.
  - Both counters=0.
- Release is honoured at the next rising edge. The first edge after release latches the word at RESET_PC.
- Latency: the word at pc_o in cycle N appears on if_id_* in cycle N+1.
- Per-edge priority, highest first:
  1. redirect_i=1:
     - pc <= {redirect_pc_i[31:2],2'b00}; low two bits are always forced to zero.
     - IF/ID <= bubble (instr=0, pc4=0, valid=0).
     - stall_i is ignored this cycle.
  2. flush_i=1 (no redirect):
     - pc <= pc+4.
     - IF/ID <= bubble.
  3. stall_i=1:
     - pc holds; IF/ID holds all fields unchanged.
     - stall_cnt increments.
  4. Otherwise:
     - pc <= pc+4.
     - IF/ID <= {pc+4, imem_instr_i, valid=1}.
     - fetch_cnt increments.
- flush_i together with stall_i: flush wins. Bubble inserted, PC advances, stall_cnt does not increment.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 0, no flag.
- Counters saturate at 2^CNT_W-1 and never wrap. Exactly one counter may increment per cycle.
- No combinational path from stall_i, flush_i or redirect_i to any output. All outputs are registered.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values immediately. No pending redirect survives.

Test Plan:
1. Reset then run free with IM[k]=k+1 (word k at byte 4k):
   - Reset low 1 cycle, then high.
   - pc_o sequence 0,4,8,12.
   - if_id_instr_o=1,2,3 on successive cycles, if_id_pc4_o=4,8,12, valid=1.
   - fetch_cnt_o=3 after 3 edges.
2. Stall at pc=8 for 2 cycles:
   - pc_o stays 8.
   - if_id_instr_o stays 2, pc4 stays 8.
   - stall_cnt_o=2, fetch_cnt_o unchanged.
   - Resumes at 3 (pc4=12).
3. Redirect at pc=12 with redirect_pc_i=32'h0000_0042:
   - Next pc_o=32'h40.
   - if_id_valid_o=0, if_id_instr_o=0.
   - Following cycle latches IM[16] with pc4=32'h44.
4. stall_i=1 and redirect_i=1 in the same cycle, target 32'h20:
   - pc_o=32'h20, bubble in IF/ID, stall_cnt unchanged.
   - Then stall_i=1 and flush_i=1 together: pc advances by 4, bubble inserted, stall_cnt unchanged.
5. Wrap and saturation:
   - Redirect to 32'hFFFF_FFFC; next free cycle pc_o=0 and if_id_pc4_o=0.
   - With CNT_W=2, 5 free-run cycles give fetch_cnt_o=3.
6. Reset mid-stall:
   - Drop rst_i between edges during a stall.
   - pc_o=RESET_PC and valid=0 immediately, without waiting for an edge.
   - Counters=0.
